sound_player: RTL and testbench
===============================

Name: sound_player

Overview:
- Consumer end of the sound-request interface driven by the sound control FSM. Turns its registered playSound level, the aligned collision/direction event class and the ON/OFF mode into a timed square-wave tone on a single speaker pin.
- Sits between game logic and the buzzer output pad.
- Three sounds, in priority order: BAD (low tone, long), GOOD (high tone, medium), MOVE (mid tone, short click).

Parameters:
- TICK_DIV, 10000, clock cycles per duration tick (1 ms at 10 MHz)
- GOOD_HALF, 4545, half-period of the GOOD tone in cycles
- BAD_HALF, 22727, half-period of the BAD tone in cycles
- MOVE_HALF, 8000, half-period of the MOVE tone in cycles
- GOOD_TICKS, 100, GOOD duration in ticks
- BAD_TICKS, 300, BAD duration in ticks
- MOVE_TICKS, 20, MOVE duration in ticks

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- playSound  in  1  registered request level from the sound FSM (one cycle behind events)
- goodColl  in  1  good-collision event
- badColl  in  1  bad-collision event
- direction  in  4  direction-press vector; any bit set is a MOVE event
- mode_i  in  MODE_TYPES  current sound mode (ON/OFF)
- speaker  out  1  square-wave output to buzzer
- busy  out  1  high while in PLAY
- sound_o  out  SOUND_TYPES  sound currently playing (SND_NONE when idle)

Behaviour:
- Reset, asynchronous on nRst low:
  - state = IDLE; speaker = 0; busy = 0; sound_o = SND_NONE.
  - All counters and registers zero; class_q = SND_NONE; play_q = 0.
- Alignment:
  - Every cycle, class_q registers the event class: badColl→SND_BAD, else goodColl→SND_GOOD, else |direction→SND_MOVE, else SND_NONE.
  - This aligns class_q with playSound.
  - play_q registers playSound for edge detection.
- Start condition in cycle N, all required:
  - mode_i==ON, playSound==1, class_q!=SND_NONE.
  - Either (state==IDLE and play_q==0), i.e. a rising edge, or (state==PLAY and class_q has strictly higher priority than sound_o), i.e. preemption.
- On start:
  - At N+1: state=PLAY, sound_o=class_q, speaker=1, busy=1.
  - Half-period counter and tick counter cleared; remaining-tick counter loaded with that sound's TICKS.
- PLAY:
  - Speaker toggles whenever the half-period counter reaches HALF-1; the counter then wraps to 0.
  - The tick counter counts 0..TICK_DIV-1. At wrap, remaining ticks decrement.
  - When the decrement takes remaining ticks from 1 to 0, the next cycle is IDLE with speaker=0, busy=0, sound_o=SND_NONE.
  - Total PLAY duration is exactly TICKS*TICK_DIV cycles.
- Equal or lower priority request during PLAY: ignored; playback continues unchanged.
- Held playSound (direction held): only one sound per rising edge. When a sound ends with playSound still high, no retrigger.
- Preemption: restarts as a fresh start with the new sound (speaker=1, counters reloaded).
- mode_i==OFF at any cycle:
  - Next cycle forces IDLE with speaker=0, busy=0, sound_o=SND_NONE.
  - No start is possible while OFF.
  - OFF takes precedence over a simultaneous start.
- Counters are sized by $clog2 of the largest parameter +1. Parameters must be ≥1; HALF=1 toggles every cycle.
- Reset mid-PLAY: immediate silence (speaker=0 asynchronously).

Decomposition:
- Shared package:
  - Existing MODE_TYPES (OFF=0, ON=1).
  - New SOUND_TYPES enum (SND_NONE=0, SND_MOVE=1, SND_GOOD=2, SND_BAD=3); numeric value is the priority.
  - PLAYER_STATE enum (IDLE, PLAY).
- Sub-module tone_divider:
  - Inputs: clk, nRst, clear, enable, half-period value.
  - Output: square wave.
  - clear forces output 1 and the count to 0.
  - Instantiated once; half-period is muxed from sound_o.

Test Plan (overrides: TICK_DIV=4, GOOD_HALF=2, BAD_HALF=5, MOVE_HALF=3, GOOD_TICKS=3, BAD_TICKS=2, MOVE_TICKS=1):
- Reset mid-operation: assert nRst low during PLAY → speaker=0, busy=0, sound_o=SND_NONE immediately; held until the first valid start after release.
- GOOD, single sample: goodColl=1 at cycle 0, playSound=1 at cycle 1, mode ON → sound_o=SND_GOOD from cycle 2; speaker 1,1,0,0,1,1…; busy high for exactly 12 cycles; then IDLE.
- MOVE preempted by BAD: MOVE started; BAD request 2 cycles into playback → restart with SND_BAD, speaker=1, busy for 8 more cycles, toggle every 5 cycles.
- Held direction: direction=4'b0001 and playSound held high for 20 cycles → exactly one 4-cycle MOVE burst (toggle every 3 cycles), no retrigger.
- Lower priority ignored: GOOD playing, MOVE request mid-play → sound_o stays SND_GOOD, total duration unchanged at 12 cycles.
- Mute: mode_i→OFF during BAD playback → next cycle speaker=0, busy=0; later requests with mode OFF produce no activity.

Source files
------------

// File: rtl/sound_player_pkg.sv
// sound_player_pkg: shared mode, sound-class and player-state types for the sound player.
package sound_player_pkg;

    typedef enum logic { OFF = 1'b0, ON = 1'b1 } MODE_TYPES;

    // Numeric value doubles as priority.
    typedef enum logic [1:0] {
        SND_NONE = 2'd0,
        SND_MOVE = 2'd1,
        SND_GOOD = 2'd2,
        SND_BAD  = 2'd3
    } SOUND_TYPES;

    typedef enum logic { IDLE = 1'b0, PLAY = 1'b1 } PLAYER_STATE;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sound_player_tone_divider.sv
// tone_divider: square wave toggling every half_i cycles; clear_i restarts it high.
module tone_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] half_i,
    output logic         wave_o
);

    logic [W-1:0] cnt_q;
    logic         wave_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            wave_q <= 1'b1;
        end else if (enable_i) begin
            cnt_q  <= (cnt_q == half_i - W'(1)) ? '0 : cnt_q + W'(1);
            wave_q <= (cnt_q == half_i - W'(1)) ? ~wave_q : wave_q;
        end
    end

    assign wave_o = wave_q;

endmodule

// File: rtl/sound_player.sv
// sound_player: turns aligned sound requests into prioritised, timed square-wave tones.
module sound_player
    import sound_player_pkg::*;
#(
    parameter int TICK_DIV   = 10000,
    parameter int GOOD_HALF  = 4545,
    parameter int BAD_HALF   = 22727,
    parameter int MOVE_HALF  = 8000,
    parameter int GOOD_TICKS = 100,
    parameter int BAD_TICKS  = 300,
    parameter int MOVE_TICKS = 20
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       playSound,
    input  logic       goodColl,
    input  logic       badColl,
    input  logic [3:0] direction,
    input  MODE_TYPES  mode_i,
    output logic       speaker,
    output logic       busy,
    output SOUND_TYPES sound_o
);

    localparam int CW = $clog2(imax(imax(imax(TICK_DIV, GOOD_HALF), imax(BAD_HALF, MOVE_HALF)),
                                    imax(imax(GOOD_TICKS, BAD_TICKS), MOVE_TICKS))) + 1;

    SOUND_TYPES  class_d, class_q, sound_q;
    PLAYER_STATE state_q;
    logic        play_q, start, wrap, wave;
    logic [CW-1:0] tick_q, rem_q, half, ticks;

    always_comb begin
        class_d = badColl ? SND_BAD : goodColl ? SND_GOOD : (|direction) ? SND_MOVE : SND_NONE;
        // Rising edge from idle, or a strictly higher-priority sound preempting playback.
        start   = mode_i == ON && playSound && class_q != SND_NONE &&
                  ((state_q == IDLE && !play_q) || (state_q == PLAY && class_q > sound_q));
        wrap    = tick_q == CW'(TICK_DIV - 1);
        half    = sound_q == SND_BAD ? CW'(BAD_HALF) : sound_q == SND_GOOD ? CW'(GOOD_HALF) : CW'(MOVE_HALF);
        ticks   = class_q == SND_BAD ? CW'(BAD_TICKS) : class_q == SND_GOOD ? CW'(GOOD_TICKS) : CW'(MOVE_TICKS);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            class_q <= SND_NONE;
            play_q  <= 1'b0;
            state_q <= IDLE;
            sound_q <= SND_NONE;
            tick_q  <= '0;
            rem_q   <= '0;
        end else begin
            class_q <= class_d;
            play_q  <= playSound;
            if (mode_i == OFF) begin
                state_q <= IDLE;
                sound_q <= SND_NONE;
                tick_q  <= '0;
                rem_q   <= '0;
            end else if (start) begin
                state_q <= PLAY;
                sound_q <= class_q;
                tick_q  <= '0;
                rem_q   <= ticks;
            end else if (state_q == PLAY) begin
                tick_q <= wrap ? '0 : tick_q + CW'(1);
                rem_q  <= wrap ? rem_q - CW'(1) : rem_q;
                if (wrap && rem_q == CW'(1)) begin
                    state_q <= IDLE;
                    sound_q <= SND_NONE;
                end
            end
        end
    end

    tone_divider #(.W(CW)) u_tone (
        .clk      (clk),
        .nRst     (nRst),
        .clear_i  (start),
        .enable_i (state_q == PLAY),
        .half_i   (half),
        .wave_o   (wave)
    );

    assign busy    = state_q == PLAY;
    assign speaker = wave & busy;
    assign sound_o = sound_q;

endmodule

// File: tb/tb_sound_player.sv
// tb_sound_player: directed checks of tone timing, priority, retrigger, mute and reset.
module tb_sound_player;
    import sound_player_pkg::*;

    logic       clk = 1'b0, nRst = 1'b0, playSound = 1'b0, goodColl = 1'b0, badColl = 1'b0;
    logic [3:0] direction = 4'd0;
    MODE_TYPES  mode_i = ON;
    logic       speaker, busy;
    SOUND_TYPES sound_o;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    sound_player #(
        .TICK_DIV(4), .GOOD_HALF(2), .BAD_HALF(5), .MOVE_HALF(3),
        .GOOD_TICKS(3), .BAD_TICKS(2), .MOVE_TICKS(1)
    ) dut (
        .clk(clk), .nRst(nRst), .playSound(playSound), .goodColl(goodColl),
        .badColl(badColl), .direction(direction), .mode_i(mode_i),
        .speaker(speaker), .busy(busy), .sound_o(sound_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_spk"}, speaker, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_snd"}, sound_o, SND_NONE);
    endtask

    // Event in one cycle, playSound rises the next; leaves playSound high.
    task automatic play(input logic g, input logic b, input logic [3:0] d);
        goodColl = g; badColl = b; direction = d;
        tick();
        goodColl = 0; badColl = 0; direction = 0; playSound = 1;
        tick();
    endtask

    task automatic burst(input string tag, input int snd, input int half, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_spk"}, speaker, ((i / half) % 2) == 0);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_snd"}, sound_o, snd);
            tick();
        end
        idle_chk({tag, "_end"});
    endtask

    initial begin
        tick();
        idle_chk("reset");
        nRst = 1;
        tick();
        idle_chk("post_reset");

        play(1, 0, 4'd0);
        playSound = 0;
        burst("good", SND_GOOD, 2, 12);
        tick();
        idle_chk("good_after");

        play(0, 0, 4'b0010);
        chk("move_start_snd", sound_o, SND_MOVE);
        chk("move_start_spk", speaker, 1);
        badColl = 1;
        tick();
        chk("move_hold_snd", sound_o, SND_MOVE);
        chk("move_hold_spk", speaker, 1);
        badColl = 0;
        tick();
        burst("bad_pre", SND_BAD, 5, 8);
        playSound = 0;
        tick();

        direction = 4'b0001;
        tick();
        playSound = 1;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("held_busy", busy, i < 4);
            chk("held_spk", speaker, i < 4 && ((i / 3) % 2) == 0);
            tick();
        end
        direction = 0; playSound = 0;
        tick();

        play(1, 0, 4'd0);
        for (int i = 0; i < 12; i++) begin
            if (i == 4) direction = 4'b1000;
            if (i == 5) direction = 0;
            chk("low_snd", sound_o, SND_GOOD);
            chk("low_busy", busy, 1);
            chk("low_spk", speaker, ((i / 2) % 2) == 0);
            tick();
        end
        idle_chk("low_end");
        tick();
        idle_chk("low_noretrig");
        playSound = 0;
        tick();

        play(0, 1, 4'd0);
        chk("mute_pre_snd", sound_o, SND_BAD);
        tick();
        chk("mute_pre_busy", busy, 1);
        mode_i = OFF;
        tick();
        idle_chk("mute");
        playSound = 0;
        tick();
        goodColl = 1;
        tick();
        goodColl = 0; playSound = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            idle_chk("mute_req");
        end
        playSound = 0; mode_i = ON;
        tick();
        idle_chk("unmute");

        play(1, 0, 4'd0);
        playSound = 0;
        tick();
        tick();
        chk("rst_pre_busy", busy, 1);
        nRst = 0;
        #1;
        idle_chk("rst_async");
        tick();
        nRst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_chk("rst_release");
        end
        play(0, 0, 4'b0100);
        burst("rst_restart", SND_MOVE, 3, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
